// File: rtl/fir_pkg.sv
// Shared constants and helpers for the transposed-form FIR PE array.
//  FIR_DEFAULT_COEF : reset values of the first eight coefficients
//                     (taps beyond index 7 reset to zero)
//  FIR_MAX_TAPS     : largest supported number of taps
//  fir_acc_w()      : accumulator width that can hold the full unsigned
//                     sum of N products without overflow
package fir_pkg;

    localparam int FIR_MAX_TAPS = 32;

    localparam int FIR_DEFAULT_COEF [8] = '{4, 12, 25, 34, 34, 25, 12, 4};

    function automatic int fir_acc_w(input int x_w, input int c_w, input int n);
        return x_w + c_w + $clog2(n);
    endfunction

endpackage

// File: rtl/fir_systolic_array_if.sv
// Stream, control and coefficient-write signals of fir_systolic_array.
//  master : sample source / coefficient writer / sink side
//           drives clr, in_valid, in_data, out_ready, coef_we, coef_addr,
//           coef_wdata; observes in_ready, out_valid, out_data, sat_flag
//  slave  : the filter itself (opposite directions)
interface fir_systolic_array_if #(
    parameter int X_W   = 4,
    parameter int C_W   = 6,
    parameter int OUT_W = 8,
    parameter int AW    = 3
);
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             sat_flag;
    logic             coef_we;
    logic [AW-1:0]    coef_addr;
    logic [C_W-1:0]   coef_wdata;

    modport master (
        output clr, in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
        input  in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  clr, in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/fir_pe.sv
// One processing element of the transposed-form FIR chain.
//  clk, rst : clock and asynchronous active-high reset
//  clr      : synchronous clear of the partial-sum register
//  en       : advance strobe (one accepted sample)
//  x, c     : current sample and this tap's coefficient
//  acc_in   : partial sum from the next-higher tap (0 for the last tap)
//  sum      : combinational x*c + acc_in
//  acc_out  : registered partial sum handed to the next-lower tap
module fir_pe #(
    parameter int X_W   = 4,
    parameter int C_W   = 6,
    parameter int ACC_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [X_W-1:0]   x,
    input  logic [C_W-1:0]   c,
    input  logic [ACC_W-1:0] acc_in,
    output logic [ACC_W-1:0] sum,
    output logic [ACC_W-1:0] acc_out
);
    logic [ACC_W-1:0] acc_q;

    assign sum     = ACC_W'(x) * ACC_W'(c) + acc_in;
    assign acc_out = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end
endmodule

// File: rtl/fir_systolic_array.sv
// N-tap transposed-form FIR with writable coefficients, valid/ready on both
// sides, synchronous clear and shifted output.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : fir_systolic_array_if.slave (stream in/out, clr, coef write)
// Optional build macro FIR_SAT_EN: clamp out_data to its maximum and raise
// sat_flag instead of wrapping; when undefined sat_flag is tied 0.
module fir_systolic_array
    import fir_pkg::*;
#(
    parameter int N_TAPS    = 8,
    parameter int X_W       = 4,
    parameter int C_W       = 6,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 5,
    localparam int ACC_W    = fir_acc_w(X_W, C_W, N_TAPS),
    localparam int AW       = $clog2(N_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_systolic_array_if.slave   bus
);
    logic [C_W-1:0]   coef_q [N_TAPS];
    logic [ACC_W-1:0] acc_chain [1:N_TAPS];
    logic [ACC_W-1:0] s_sum;
    logic [ACC_W-1:0] t_scaled;
    logic [OUT_W-1:0] out_data_d;
    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             in_ready_w;
    logic             fire;

    // Downstream can take a new result whenever the output register is empty
    // or being drained this cycle, so full throughput has no bubble.
    assign in_ready_w   = !out_valid_q || bus.out_ready;
    assign fire         = bus.in_valid && in_ready_w;
    assign bus.in_ready = in_ready_w;

    // Coefficient register file; a write landing on a fire edge is seen only
    // by later samples because the PEs sample coef_q before the edge.
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_coef
        localparam logic [C_W-1:0] RST_VAL =
            (gi < 8) ? C_W'(FIR_DEFAULT_COEF[gi % 8]) : '0;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                coef_q[gi] <= RST_VAL;
            end else if (bus.coef_we && bus.coef_addr == AW'(gi)) begin
                coef_q[gi] <= bus.coef_wdata;
            end
        end
    end

    assign acc_chain[N_TAPS] = '0;

    // Tap 0 contributes only its combinational sum; higher taps pass their
    // registered partial sums down the chain.
    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_pe
        if (gi == 0) begin : g_head
            logic [ACC_W-1:0] acc_unused;
            fir_pe #(.X_W(X_W), .C_W(C_W), .ACC_W(ACC_W)) u_pe (
                .clk    (clk),
                .rst    (rst),
                .clr    (bus.clr),
                .en     (fire),
                .x      (bus.in_data),
                .c      (coef_q[gi]),
                .acc_in (acc_chain[gi+1]),
                .sum    (s_sum),
                .acc_out(acc_unused)
            );
        end else begin : g_tail
            logic [ACC_W-1:0] sum_unused;
            fir_pe #(.X_W(X_W), .C_W(C_W), .ACC_W(ACC_W)) u_pe (
                .clk    (clk),
                .rst    (rst),
                .clr    (bus.clr),
                .en     (fire),
                .x      (bus.in_data),
                .c      (coef_q[gi]),
                .acc_in (acc_chain[gi+1]),
                .sum    (sum_unused),
                .acc_out(acc_chain[gi])
            );
        end
    end

    assign t_scaled = s_sum >> OUT_SHIFT;

`ifdef FIR_SAT_EN
    logic sat_d;
    logic sat_q;

    // Any set bit above the output width means the value does not fit.
    always_comb begin
        out_data_d = OUT_W'(t_scaled);
        sat_d      = 1'b0;
        if ((t_scaled >> OUT_W) != '0) begin
            out_data_d = '1;
            sat_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (!bus.clr && fire) begin
            sat_q <= sat_d;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    assign out_data_d   = OUT_W'(t_scaled);
    assign bus.sat_flag = 1'b0;
`endif

    // Output register: clear wins over fire; a drained result with no new
    // sample empties the register but keeps the last data value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (bus.clr) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule
